// File: rtl/cd_byte_fifo.sv
// Byte-in, 1/2/4-byte-out show-ahead FIFO for the CD-ROM data path.
// Occupancy is tracked by an explicit count; pointers wrap modulo DEPTH.
module cd_byte_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned THRESH = 8,
  parameter int unsigned CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [1:0]    rsize,
  output logic [31:0]   rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          lvl_hit,
  output logic          ovf,
  output logic          udf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic [CW-1:0] req_c;
  logic [CW-1:0] consumed_c;
  logic          push_c;
  logic          short_c;
  logic          mem_we_c;

  // Pop request size and how much of it can actually be served
  always_comb begin
    unique case (rsize)
      2'd0:    req_c = CW'(1);
      2'd1:    req_c = CW'(2);
      default: req_c = CW'(4);
    endcase
    short_c    = re && (req_c > count_q);
    consumed_c = '0;
    if (re) begin
      consumed_c = short_c ? count_q : req_c;
    end
    // A full FIFO still accepts a byte when a slot is freed in the same cycle
    push_c   = we && ((count_q != CW'(DEPTH)) || (consumed_c != '0));
    mem_we_c = push_c && !clr;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(consumed_c);
      wr_ptr_d = wr_ptr_q + AW'(push_c);
      count_d  = count_q - consumed_c + CW'(push_c);
      ovf_d    = ovf_q | (we && !push_c);
      udf_d    = udf_q | short_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Show-ahead: bytes beyond the stored count read as zero
  always_comb begin
    rdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (CW'(k) < count_q) begin
        rdata[8*k +: 8] = mem_q[rd_ptr_q + AW'(k)];
      end
    end
  end

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign lvl_hit = (count_q >= CW'(THRESH));
  assign ovf     = ovf_q;
  assign udf     = udf_q;

endmodule

// File: tb/tb_cd_byte_fifo.sv
// Directed self-checking bench for cd_byte_fifo (DEPTH=16, THRESH=8).
module tb_cd_byte_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          we;
  logic [7:0]    wdata;
  logic          re;
  logic [1:0]    rsize;
  logic [31:0]   rdata;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          lvl_hit;
  logic          ovf;
  logic          udf;

  int checks;
  int errors;

  cd_byte_fifo #(.DEPTH(16), .THRESH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wdata(wdata), .re(re),
    .rsize(rsize), .rdata(rdata), .count(count), .empty(empty), .full(full),
    .lvl_hit(lvl_hit), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given controls, then idle inputs 1ns after the edge
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic [1:0] s, input logic c);
    we = w; wdata = d; re = r; rsize = s; clr = c;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; clr = 1'b0; rsize = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0; wdata = '0; rsize = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({count, empty, full, lvl_hit, ovf, udf, rdata} !== {5'd0, 5'b10000, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b l=%b o=%b u=%b rd=%h expected cnt=0 e=1 f=0 l=0 o=0 u=0 rd=0",
               count, empty, full, lvl_hit, ovf, udf, rdata);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_pop4();
    step(1, 8'h11, 0, 0, 0); step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0); step(1, 8'h44, 0, 0, 0);
    checks++;
    if (rdata !== 32'h44332211 || count !== 5'd4) begin
      errors++;
      $display("FAIL basic_pre_pop: got rd=%h cnt=%0d expected rd=44332211 cnt=4", rdata, count);
    end
    step(0, 8'h00, 1, 2'd2, 0);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || rdata !== 32'h0 || udf !== 1'b0) begin
      errors++;
      $display("FAIL basic_post_pop: got cnt=%0d e=%b rd=%h u=%b expected cnt=0 e=1 rd=0 u=0",
               count, empty, rdata, udf);
    end
  endtask

  task automatic test_fill_overflow();
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0, 0);
      checks++;
      if (lvl_hit !== (i >= 7) || full !== (i == 15)) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got l=%b f=%b expected l=%b f=%b", i, lvl_hit, full, i >= 7, i == 15);
      end
    end
    step(1, 8'hAA, 0, 0, 0);
    checks++;
    if (ovf !== 1'b1 || count !== 5'd16 || rdata !== 32'h03020100) begin
      errors++;
      $display("FAIL overflow_drop: got o=%b cnt=%0d rd=%h expected o=1 cnt=16 rd=03020100", ovf, count, rdata);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] nxt;
    logic [1:0] sizes [5];
    int req;
    sizes[0] = 2'd0; sizes[1] = 2'd1; sizes[2] = 2'd0; sizes[3] = 2'd1; sizes[4] = 2'd1;
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (rdata !== {8'(8'h23 + 4*p), 8'(8'h22 + 4*p), 8'(8'h21 + 4*p), 8'(8'h20 + 4*p)}) begin
        errors++;
        $display("FAIL wrap_pop4[%0d]: got rd=%h expected base %h", p, rdata, 8'h20 + 4*p);
      end
      step(0, 8'h00, 1, 2'd2, 0);
      checks++;
      if (count !== 5'(8 - 4*p) || udf !== 1'b0) begin
        errors++;
        $display("FAIL wrap_count[%0d]: got cnt=%0d u=%b expected cnt=%0d u=0", p, count, udf, 8 - 4*p);
      end
    end
    step(0, 8'h00, 1, 2'd2, 0);
    checks++;
    if (udf !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL wrap_udf: got u=%b cnt=%0d expected u=1 cnt=0", udf, count);
    end
    // Pointers sit at 12: these bytes straddle the mem[15]->mem[0] boundary
    for (int i = 0; i < 8; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
    step(0, 8'h00, 1, 2'd1, 0);
    checks++;
    if (rdata !== 32'h35343332 || count !== 5'd6) begin
      errors++;
      $display("FAIL wrap_boundary: got rd=%h cnt=%0d expected rd=35343332 cnt=6", rdata, count);
    end
    step(0, 8'h00, 0, 0, 1);
    checks++;
    if (udf !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_clr: got u=%b e=%b expected u=0 e=1", udf, empty);
    end
    for (int i = 0; i < 14; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    nxt = 8'h40;
    for (int p = 0; p < 5; p++) begin
      req = (sizes[p] == 2'd0) ? 1 : 2;
      for (int j = 0; j < req; j++) begin
        checks++;
        if (rdata[8*j +: 8] !== 8'(nxt + 8'(j))) begin
          errors++;
          $display("FAIL mixed_pop[%0d.%0d]: got %h expected %h", p, j, rdata[8*j +: 8], nxt + 8'(j));
        end
      end
      step(0, 8'h00, 1, sizes[p], 0);
      nxt = nxt + 8'(req);
    end
    checks++;
    if (count !== 5'd6 || rdata !== 32'h4B4A4948 || udf !== 1'b0) begin
      errors++;
      $display("FAIL mixed_end: got cnt=%0d rd=%h u=%b expected cnt=6 rd=4B4A4948 u=0", count, rdata, udf);
    end
  endtask

  task automatic test_full_push_pop();
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    step(1, 8'h5A, 1, 2'd0, 0);
    checks++;
    if (count !== 5'd16 || ovf !== 1'b0 || full !== 1'b1 || rdata !== 32'h14131211) begin
      errors++;
      $display("FAIL full_rw: got cnt=%0d o=%b f=%b rd=%h expected cnt=16 o=0 f=1 rd=14131211",
               count, ovf, full, rdata);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rdata[7:0] !== ((i == 15) ? 8'h5A : 8'(8'h11 + i))) begin
        errors++;
        $display("FAIL drain[%0d]: got %h expected %h", i, rdata[7:0], (i == 15) ? 8'h5A : 8'(8'h11 + i));
      end
      step(0, 8'h00, 1, 2'd0, 0);
    end
    checks++;
    if (empty !== 1'b1 || udf !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: got e=%b u=%b expected e=1 u=0", empty, udf);
    end
  endtask

  task automatic test_short_pop();
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'hA1, 0, 0, 0); step(1, 8'hA2, 0, 0, 0); step(1, 8'hA3, 0, 0, 0);
    checks++;
    if (rdata !== 32'h00A3A2A1) begin
      errors++;
      $display("FAIL short_pre: got rd=%h expected 00A3A2A1", rdata);
    end
    step(0, 8'h00, 1, 2'd3, 0);
    checks++;
    if (count !== 5'd0 || udf !== 1'b1) begin
      errors++;
      $display("FAIL short_post: got cnt=%0d u=%b expected cnt=0 u=1", count, udf);
    end
    step(0, 8'h00, 0, 0, 1);
    checks++;
    if (udf !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL short_clr: got u=%b e=%b expected u=0 e=1", udf, empty);
    end
    // Pop on empty with a push: underflow flagged, byte still accepted
    step(1, 8'hC7, 1, 2'd0, 0);
    checks++;
    if (count !== 5'd1 || udf !== 1'b1 || ovf !== 1'b0 || rdata !== 32'h000000C7) begin
      errors++;
      $display("FAIL empty_rw: got cnt=%0d u=%b o=%b rd=%h expected cnt=1 u=1 o=0 rd=000000C7",
               count, udf, ovf, rdata);
    end
  endtask

  task automatic test_clr_priority_and_async_rst();
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    step(1, 8'h99, 1, 2'd2, 1);
    checks++;
    if (count !== 5'd0 || ovf !== 1'b0 || udf !== 1'b0 || empty !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL clr_prio: got cnt=%0d o=%b u=%b e=%b rd=%h expected cnt=0 o=0 u=0 e=1 rd=0",
               count, ovf, udf, empty, rdata);
    end
    step(1, 8'h77, 0, 0, 0);
    checks++;
    if (rdata !== 32'h00000077 || count !== 5'd1) begin
      errors++;
      $display("FAIL clr_absent: got rd=%h cnt=%0d expected rd=00000077 cnt=1", rdata, count);
    end
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
    // Now full with ovf set; hit rst between edges while traffic is active
    we = 1'b1; wdata = 8'hEE; re = 1'b1; rsize = 2'd0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({count, empty, full, lvl_hit, ovf, udf, rdata} !== {5'd0, 5'b10000, 32'h0}) begin
      errors++;
      $display("FAIL async_rst: got cnt=%0d e=%b f=%b l=%b o=%b u=%b rd=%h expected reset values",
               count, empty, full, lvl_hit, ovf, udf, rdata);
    end
    we = 1'b0; re = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 8'h3C, 0, 0, 0);
    checks++;
    if (count !== 5'd1 || rdata !== 32'h0000003C) begin
      errors++;
      $display("FAIL post_rst: got cnt=%0d rd=%h expected cnt=1 rd=0000003C", count, rdata);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_pop4();
    test_fill_overflow();
    test_wrap();
    test_full_push_pop();
    test_short_pop();
    test_clr_priority_and_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cd_byte_fifo.md
Name: cd_byte_fifo

Overview:
Parametrised byte-in, multi-width-out FIFO for the CD-ROM data path. The drive side pushes one byte per cycle. The host/DMA side pops 1, 2 or 4 bytes per cycle as a little-endian word. It replaces the fixed 16-entry, 8/16-bit-read buffer with these additions:
- configurable depth
- 32-bit reads
- true wrap-around pointers and an occupancy count
- concurrent read/write
- sticky overflow/underflow flags
- a programmable level flag for DMA requests

Parameters:
DEPTH, 16, number of byte entries; power of two, >= 4.
THRESH, 8, level at or above which lvl_hit asserts; 1..DEPTH.
CW, $clog2(DEPTH)+1, count width (derived, do not override).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
clr  in  1  synchronous flush.
we  in  1  push wdata this cycle.
wdata  in  8  byte to push.
re  in  1  pop this cycle.
rsize  in  2  pop size: 0=1 byte, 1=2 bytes, 2=4 bytes, 3=reserved (treated as 4).
rdata  out  32  show-ahead head data; byte k = entry head+k.
count  out  CW  bytes currently stored, 0..DEPTH.
empty  out  1  count==0.
full  out  1  count==DEPTH.
lvl_hit  out  1  count>=THRESH.
ovf  out  1  sticky: a write was dropped.
udf  out  1  sticky: a pop requested more bytes than stored.

Behaviour:
- Reset (rst=1, async) state:
  - rd_ptr, wr_ptr, count = 0; ovf = udf = 0.
  - Outputs: empty=1, full=0, lvl_hit=0, rdata=0.
  - Storage array is not reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy comes from count, never from pointer comparison.
- rdata is combinational from registered state (zero read latency):
  - byte k (k=0..3) = mem[(rd_ptr+k) mod DEPTH] if k<count, else 8'h00.
  - rdata is independent of rsize; the consumer masks unused bytes.
- Pop:
  - req = 1/2/4 per rsize. consumed = min(req, count).
  - rd_ptr += consumed.
  - If req > count, set udf; the FIFO drains to empty and no other state changes.
- Push:
  - accepted if count < DEPTH, or if re=1 and consumed >= 1 in the same cycle (push into a slot freed this cycle).
  - On accept: mem[wr_ptr] <= wdata, wr_ptr += 1.
  - If we=1 and not accepted: byte dropped, ovf set, wr_ptr unchanged.
- Simultaneous push and pop:
  - count_next = count - consumed + accepted.
  - A pushed byte is never visible in rdata in the same cycle; it appears the next cycle.
  - Pop on empty plus push: consumed=0, udf set, byte accepted, count becomes 1.
- clr has priority over we/re:
  - rd_ptr, wr_ptr, count, ovf, udf <= 0.
  - we and re are ignored that cycle; no flag is set by them.
- Flags full, empty and lvl_hit are combinational from registered count and valid the cycle after any change.
- ovf and udf stay set until clr or rst.
- rst asserted mid-transfer aborts immediately; no partial state survives.
- Implementation may use a flop array or an inferred RAM, but rdata must meet the zero-latency show-ahead rule above.

Test Plan:
All scenarios use DEPTH=16, THRESH=8.
1. After rst, push 0x11,0x22,0x33,0x44, then pop rsize=2 -> before the pop: rdata=0x44332211, count=4. After the pop: count=0, empty=1, rdata=0.
2. Push 16 bytes 0x00..0x0F -> full=1, lvl_hit=1 from count 8. A 17th push (0xAA) with no pop -> dropped, ovf=1, count=16, head byte still 0x00.
3. Wrap: push 12, pop 4x rsize=2 (count 12->...->0 after 3 pops; 4th pop udf), clr, then push 14 and pop 8 via rsize=0/1 mixes -> bytes emerge in order across the mem[15]->mem[0] boundary. Pointer values wrap, no data corruption.
4. Full FIFO, same cycle we=1 wdata=0x5A plus re=1 rsize=0 -> push accepted, count stays 16, ovf=0. The last byte read out after draining is 0x5A.
5. count=3 (0xA1,0xA2,0xA3), pop rsize=2 -> before the pop: rdata=0x00A3A2A1. After: count=0, udf=1. A following clr -> udf=0, empty=1.
6. count=5 with clr, we and re all high in one cycle -> count=0, no flags set, the pushed byte is absent. rst pulsed asynchronously mid-stream -> all outputs at reset values without waiting for a clock edge.
